// File: rtl/eluks_wb_slave.sv
// Wishbone slave front-end of the ELUKS core: config registers plus
// status/byte request handshakes toward the decrypt core.
module eluks_wb_slave #(
    parameter int          WB_DATA   = 32,
    parameter logic [31:0] BASE_ADDR = 32'h92000000,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        wb_clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [63:0] psw,
    output logic [31:0] start_block,
    output logic [31:0] block_dir,
    output logic        hmac_enable,
    output logic        status_rq,
    input  logic        status_ready,
    input  logic [31:0] status_i,
    output logic        byte_rq,
    input  logic        byte_valid,
    input  logic [7:0]  byte_i
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]   ERR_RSP = 32'h80000000;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_STATUS, S_WAIT_BYTE, S_ACK, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   psw_hi_q, psw_hi_d, psw_lo_q, psw_lo_d;
    logic [31:0]   start_q, start_d, dir_q, dir_d, rdata_q, rdata_d;
    logic          hmac_q, hmac_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] off;
    logic        strobe, in_range, timeout_hit;
    logic        unused_ok;

    assign off         = wb_adr_i - BASE_ADDR;
    assign strobe      = wb_cyc_i & wb_stb_i;
    assign in_range    = (off <= 32'd6);
    assign timeout_hit = (cnt_q == TO_LAST);
    assign unused_ok   = ^{wb_cti_i, wb_bte_i};

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    always_ff @(posedge wb_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            psw_hi_q <= '0;
            psw_lo_q <= '0;
            start_q  <= '0;
            dir_q    <= '0;
            hmac_q   <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            psw_hi_q <= psw_hi_d;
            psw_lo_q <= psw_lo_d;
            start_q  <= start_d;
            dir_q    <= dir_d;
            hmac_q   <= hmac_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Dropping cyc while waiting on the core abandons the request silently.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    if (!in_range)
                        state_d = S_ERR;
                    else if (wb_we_i && off[2:0] == 3'd6 && wb_dat_i[0])
                        state_d = S_WAIT_STATUS;
                    else if (wb_we_i && off[2:0] == 3'd5 && wb_dat_i[0])
                        state_d = S_WAIT_BYTE;
                    else
                        state_d = S_ACK;
                end
            end
            S_WAIT_STATUS: begin
                if (!wb_cyc_i)                        state_d = S_IDLE;
                else if (status_ready || timeout_hit) state_d = S_ACK;
            end
            S_WAIT_BYTE: begin
                if (!wb_cyc_i)                      state_d = S_IDLE;
                else if (byte_valid || timeout_hit) state_d = S_ACK;
            end
            S_ACK, S_ERR: begin
                if (!wb_stb_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wb_ack_o  = (state_q == S_ACK);
        wb_err_o  = (state_q == S_ERR);
        status_rq = (state_q == S_WAIT_STATUS);
        byte_rq   = (state_q == S_WAIT_BYTE);
    end

    always_comb begin
        psw_hi_d = psw_hi_q;
        psw_lo_d = psw_lo_q;
        start_d  = start_q;
        dir_d    = dir_q;
        hmac_d   = hmac_q;
        rdata_d  = rdata_q;
        cnt_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (strobe && in_range) begin
                    if (wb_we_i) begin
                        case (off[2:0])
                            3'd0: psw_hi_d = merge(psw_hi_q, wb_dat_i, wb_sel_i);
                            3'd1: psw_lo_d = merge(psw_lo_q, wb_dat_i, wb_sel_i);
                            3'd2: start_d  = merge(start_q, wb_dat_i, wb_sel_i);
                            3'd3: dir_d    = merge(dir_q, wb_dat_i, wb_sel_i);
                            3'd4: if (wb_sel_i[0]) hmac_d = wb_dat_i[0];
                            default: ;
                        endcase
                    end else begin
                        case (off[2:0])
                            3'd0: rdata_d = psw_hi_q;
                            3'd1: rdata_d = psw_lo_q;
                            3'd2: rdata_d = start_q;
                            3'd3: rdata_d = dir_q;
                            3'd4: rdata_d = {31'd0, hmac_q};
                            default: ;
                        endcase
                    end
                end
            end
            S_WAIT_STATUS: begin
                if (wb_cyc_i) begin
                    cnt_d = cnt_q + CW'(1);
                    if (status_ready)     rdata_d = status_i;
                    else if (timeout_hit) rdata_d = ERR_RSP;
                end
            end
            S_WAIT_BYTE: begin
                if (wb_cyc_i) begin
                    cnt_d = cnt_q + CW'(1);
                    if (byte_valid)       rdata_d = {24'd0, byte_i};
                    else if (timeout_hit) rdata_d = ERR_RSP;
                end
            end
            default: ;
        endcase
    end

    assign wb_dat_o    = rdata_q;
    assign wb_rty_o    = 1'b0;
    assign psw         = {psw_hi_q, psw_lo_q};
    assign start_block = start_q;
    assign block_dir   = dir_q;
    assign hmac_enable = hmac_q;

endmodule

// File: tb/tb_eluks_wb_slave.sv
// Directed + randomized bench for eluks_wb_slave against a register/response model.
module tb_eluks_wb_slave;

    localparam logic [31:0] BASE = 32'h92000000;
    localparam int          TO   = 16;

    logic        wb_clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [63:0] psw;
    logic [31:0] start_block, block_dir;
    logic        hmac_enable, status_rq, status_ready, byte_rq, byte_valid;
    logic [31:0] status_i;
    logic [7:0]  byte_i;

    int checks = 0;
    int errors = 0;

    // Reference state: four 32-bit config words, hmac bit and last returned data.
    logic [31:0] m_reg [4];
    logic        m_hmac;
    logic [31:0] m_rdata;

    eluks_wb_slave #(.WB_DATA(32), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .wb_clk(wb_clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .psw(psw), .start_block(start_block), .block_dir(block_dir), .hmac_enable(hmac_enable),
        .status_rq(status_rq), .status_ready(status_ready), .status_i(status_i),
        .byte_rq(byte_rq), .byte_valid(byte_valid), .byte_i(byte_i)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_hmac  = 1'b0;
        m_rdata = '0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_psw"}, psw, {m_reg[0], m_reg[1]});
        chk({tag, "_start"}, {32'd0, start_block}, {32'd0, m_reg[2]});
        chk({tag, "_dir"}, {32'd0, block_dir}, {32'd0, m_reg[3]});
        chk({tag, "_hmac"}, {63'd0, hmac_enable}, {63'd0, m_hmac});
        chk({tag, "_dat"}, {32'd0, wb_dat_o}, {32'd0, m_rdata});
    endtask

    // One plain bus access: ack (or err) expected exactly one cycle after strobe.
    task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, input bit exp_err);
        int  n;
        bit  done;
        @(negedge wb_clk);
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0; done = 0;
        while (!done && n < 50) begin
            @(negedge wb_clk);
            n++;
            if (wb_ack_o || wb_err_o) done = 1;
        end
        chk("xfer_done", {63'd0, done}, 64'd1);
        chk("xfer_lat", 64'(n), 64'd1);
        chk("xfer_kind", {62'd0, wb_ack_o, wb_err_o}, exp_err ? 64'd1 : 64'd2);
        chk("xfer_rq", {62'd0, status_rq, byte_rq}, 64'd0);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        @(negedge wb_clk);
        chk("xfer_release", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = v[8*b +: 8];
        return r;
    endfunction

    task automatic cfg_wr(input int off, input logic [31:0] dat, input logic [3:0] sel);
        xfer(BASE + 32'(off), dat, sel, 1'b1, 1'b0);
        if (off < 4) m_reg[off] = lanes(m_reg[off], dat, sel);
        else if (sel[0]) m_hmac = dat[0];
        chk_state("cfg_wr");
    endtask

    task automatic cfg_rd(input int off);
        xfer(BASE + 32'(off), $urandom, 4'hF, 1'b0, 1'b0);
        if (off < 4)       m_rdata = m_reg[off];
        else if (off == 4) m_rdata = {31'd0, m_hmac};
        chk_state("cfg_rd");
    endtask

    task automatic bad_access(input logic [31:0] adr);
        xfer(adr, $urandom, 4'hF, 1'($urandom_range(0, 1)), 1'b1);
        chk_state("err_access");
    endtask

    // Request through offset 6 (status) or 5 (byte); core answers on the delay-th request cycle.
    task automatic core_req(input bit is_status, input int delay, input bit silent,
                            input logic [31:0] resp);
        int  n, rqn;
        bit  done;
        logic [31:0] exp;
        @(negedge wb_clk);
        wb_adr_i = BASE + (is_status ? 32'd6 : 32'd5);
        wb_dat_i = $urandom | 32'd1; wb_sel_i = 4'hF; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0; rqn = 0; done = 0;
        while (!done && n < 100) begin
            @(negedge wb_clk);
            status_ready = 1'b0; byte_valid = 1'b0;
            n++;
            if (wb_ack_o) done = 1;
            else begin
                if (is_status ? status_rq : byte_rq) rqn++;
                if (!silent && rqn == delay) begin
                    if (is_status) begin status_ready = 1'b1; status_i = resp; end
                    else begin byte_valid = 1'b1; byte_i = resp[7:0]; end
                end
            end
        end
        chk("req_done", {63'd0, done}, 64'd1);
        chk("req_rq_cycles", 64'(rqn), silent ? 64'(TO) : 64'(delay));
        chk("req_rq_in_ack", {62'd0, status_rq, byte_rq}, 64'd0);
        exp = silent ? 32'h80000000 : (is_status ? resp : {24'd0, resp[7:0]});
        m_rdata = exp;
        chk("req_dat", {32'd0, wb_dat_o}, {32'd0, exp});
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        @(negedge wb_clk);
        chk("req_ack_fall", {63'd0, wb_ack_o}, 64'd0);
        chk_state("req_after");
    endtask

    initial begin
        rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = '0; wb_bte_i = '0;
        status_ready = 1'b0; status_i = '0; byte_valid = 1'b0; byte_i = '0;
        model_reset();
        repeat (3) @(negedge wb_clk);
        chk_state("reset");
        chk("reset_ctl", {59'd0, wb_ack_o, wb_err_o, wb_rty_o, status_rq, byte_rq}, 64'd0);
        rst = 1'b0;

        // Directed config writes and byte-lane merge
        cfg_wr(0, 32'h11223344, 4'hF);
        cfg_wr(1, 32'h55667788, 4'hF);
        cfg_wr(2, 32'h00000040, 4'hF);
        cfg_wr(3, 32'h00000040, 4'hF);
        cfg_wr(4, 32'h00000001, 4'hF);
        chk("psw_fixed", psw, 64'h1122334455667788);
        cfg_wr(2, 32'h0, 4'hF);
        cfg_wr(2, 32'hAABBCCDD, 4'b0101);
        chk("lane_fixed", {32'd0, start_block}, 64'h00BB00DD);
        cfg_wr(4, 32'h0, 4'b1110);
        for (int o = 0; o < 5; o++) cfg_rd(o);

        // Status request answered on the 5th request cycle
        core_req(1'b1, 5, 1'b0, 32'h00000003);
        chk("status_fixed", {32'd0, wb_dat_o}, 64'h3);

        // Byte stream, then a spurious byte pulse in idle
        core_req(1'b0, 1, 1'b0, 32'hDE);
        core_req(1'b0, 2, 1'b0, 32'hAD);
        core_req(1'b0, 3, 1'b0, 32'hBE);
        core_req(1'b0, 4, 1'b0, 32'hEF);
        chk("byte_fixed", {32'd0, wb_dat_o}, 64'hEF);
        @(negedge wb_clk); byte_valid = 1'b1; byte_i = 8'h55;
        @(negedge wb_clk); byte_valid = 1'b0;
        @(negedge wb_clk);
        chk_state("spurious_byte");

        // Timeout, request bit clear, reads of 5/6, unmapped addresses
        core_req(1'b1, 1, 1'b1, 32'h0);
        core_req(1'b0, 1, 1'b1, 32'h0);
        xfer(BASE + 32'd6, 32'hFFFFFFFE, 4'hF, 1'b1, 1'b0);
        chk_state("off6_noreq");
        cfg_rd(5);
        cfg_rd(6);
        bad_access(BASE + 32'd7);
        bad_access(BASE - 32'd1);

        // Abort: drop cyc while waiting for a byte
        @(negedge wb_clk);
        wb_adr_i = BASE + 32'd5; wb_dat_i = 32'h1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (3) @(negedge wb_clk);
        chk("abort_rq_before", {63'd0, byte_rq}, 64'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge wb_clk);
        chk("abort_rq_after", {62'd0, byte_rq, wb_ack_o}, 64'd0);
        byte_valid = 1'b1; byte_i = 8'h77;
        @(negedge wb_clk); byte_valid = 1'b0;
        @(negedge wb_clk);
        chk_state("abort");

        // Reset during WAIT_STATUS
        @(negedge wb_clk);
        wb_adr_i = BASE + 32'd6; wb_dat_i = 32'h1; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (2) @(negedge wb_clk);
        chk("rst_rq_before", {63'd0, status_rq}, 64'd1);
        rst = 1'b1;
        @(negedge wb_clk);
        model_reset();
        chk_state("rst_mid");
        chk("rst_mid_ctl", {59'd0, wb_ack_o, wb_err_o, wb_rty_o, status_rq, byte_rq}, 64'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        rst = 1'b0;
        @(negedge wb_clk);

        // Randomized mix against the model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0, 1: cfg_wr($urandom_range(0, 4), $urandom, 4'($urandom));
                2:    cfg_rd($urandom_range(0, 6));
                3:    core_req(1'b1, $urandom_range(1, 8), $urandom_range(0, 7) == 0, $urandom);
                4:    core_req(1'b0, $urandom_range(1, 8), $urandom_range(0, 7) == 0, $urandom);
                default:
                    if ($urandom_range(0, 1) == 1) bad_access(BASE + 32'($urandom_range(7, 100000)));
                    else                           bad_access(BASE - 32'($urandom_range(1, 100000)));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eluks_wb_slave.md
Name: eluks_wb_slave

Overview:
- Wishbone slave front-end of the ELUKS core. It is the responder the boot loader master talks to.
- Decodes seven word-indexed registers at BASE_ADDR+0..+6. Holds the configuration values: password, start block, block directory and HMAC enable.
- Converts writes to the status and data request registers into request/response handshakes with the ELUKS decrypt core.
- Returns the core's answer on wb_dat_o with ack-until-strobe-drop signalling.

Parameters:
- WB_DATA, 32, Wishbone data/address width. Only 32 is supported.
- BASE_ADDR, 32'h92000000, base address. Register offsets are +1 per register, not +4.
- TIMEOUT, 1024, maximum core-wait cycles before an error response is returned.

Ports:
- wb_clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_adr_i  in  32  address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte enables
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  ignored
- wb_bte_i  in  2  ignored
- wb_dat_o  out  32  read / response data
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  bus error (unmapped address)
- wb_rty_o  out  1  tied 0
- psw  out  64  password; offset 0 = [63:32], offset 1 = [31:0]
- start_block  out  32  offset 2
- block_dir  out  32  offset 3
- hmac_enable  out  1  offset 4, bit0
- status_rq  out  1  status request level to core
- status_ready  in  1  core status valid (1-cycle pulse)
- status_i  in  32  bit31 = error, [30:0] = total blocks
- byte_rq  out  1  next-plaintext-byte request level
- byte_valid  in  1  core byte valid (1-cycle pulse)
- byte_i  in  8  plaintext byte

Behaviour:
- Reset values: all outputs 0, including the config registers and rdata. FSM goes to IDLE. Reset mid-transaction aborts immediately and drops any request.
- FSM states: IDLE, WAIT_STATUS, WAIT_BYTE, ACK, ERR.
- IDLE, waiting for a cycle:
  - Acts on wb_cyc_i & wb_stb_i. off = wb_adr_i - BASE_ADDR.
  - off > 6 (unsigned, wrap-around included) -> ERR.
- IDLE, writes to config offsets 0..4:
  - Update the register per wb_sel_i byte lane in that cycle. hmac_enable takes bit0 only, qualified by sel[0].
  - Go to ACK.
- IDLE, write to offset 6:
  - If wb_dat_i[0]=1 -> WAIT_STATUS.
  - Else go to ACK with no request.
- IDLE, write to offset 5:
  - If wb_dat_i[0]=1 -> WAIT_BYTE.
  - Else go to ACK with no request.
- IDLE, reads:
  - Offsets 0..4: rdata = register value; hmac is zero-extended.
  - Offsets 5/6: rdata unchanged.
  - Go to ACK.
- WAIT_STATUS:
  - status_rq=1 and the timeout counter increments.
  - On status_ready: rdata = status_i -> ACK.
  - On counter = TIMEOUT-1: rdata = 32'h80000000 -> ACK.
- WAIT_BYTE:
  - byte_rq=1 with the same timer.
  - On byte_valid: rdata = {24'h0, byte_i} -> ACK.
  - On timeout: rdata = 32'h80000000 -> ACK.
- Core pulses are sampled only in the matching WAIT state. Pulses in any other state are ignored.
- Abort on cyc drop: if wb_cyc_i=0 in a WAIT state -> IDLE, request dropped, rdata unchanged, no ack.
- ACK:
  - wb_ack_o=1, registered, equal to (state==ACK).
  - When wb_stb_i=0 -> IDLE. The ack therefore falls one cycle after stb falls, and the master waits for ack negation.
- ERR: wb_err_o=1 until wb_stb_i=0, then IDLE. No register changes.
- wb_dat_o = rdata at all times. It stays stable after ack falls until the next read or request completes, because the master samples status after ack negation.
- Latency:
  - Config write/read: ack asserted 1 cycle after the strobe is sampled.
  - Request: ack asserted 1 cycle after the core pulse.
- Only one transaction is in flight. A new strobe is not accepted until the FSM is back in IDLE.

Test Plan:
- Config writes: write 0x11223344 to off0, 0x55667788 to off1, 0x00000040 to off2, 0x00000040 to off3, 0x1 to off4, all with sel=4'hF -> psw=0x1122334455667788, start_block=0x40, block_dir=0x40, hmac_enable=1. Each ack asserts 1 cycle after stb and falls 1 cycle after stb drops.
- Byte-lane write: write 0xAABBCCDD to off2 with sel=4'b0101 after a previous value of 0 -> start_block=0x00BB00DD.
- Status request: write 0x1 to off6, core answers status_ready after 5 cycles with status_i=0x00000003 -> status_rq high for exactly 5 cycles. ack then asserts, and wb_dat_o=0x00000003 and stays so after ack drops.
- Byte stream: four writes of 0x1 to off5 with core bytes 0xDE, 0xAD, 0xBE, 0xEF -> successive wb_dat_o = 0x000000DE, 0x000000AD, 0x000000BE, 0x000000EF. A spurious byte_valid in IDLE leaves wb_dat_o unchanged.
- Timeout and error: write 0x1 to off6 with the core silent and TIMEOUT=16 -> ack after 16 wait cycles with wb_dat_o=0x80000000. An access to BASE_ADDR+7 or BASE_ADDR-1 -> wb_err_o=1, no ack, registers unchanged.
- Abort and reset: drop cyc during WAIT_BYTE -> byte_rq falls the next cycle with no ack. Assert rst during WAIT_STATUS -> all outputs 0 next cycle and FSM in IDLE.
